// File: rtl/apb_decoder_pkg.sv
// Shared types and default region map for the APB decoder slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DERR   = 2'd2
  } apb_dec_state_t;

  localparam int DEF_NUM_SLAVES = 4;

  // Index 0 is the rightmost element: slave0 owns the 4 KiB page at address zero.
  localparam logic [3:0][31:0] DEF_SLV_BASE = {
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [3:0][31:0] DEF_SLV_MASK = {
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000
  };

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; the decoder attaches through the Slave modport.
interface APB #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport Slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output prdata, pready, pslverr
  );

  modport Master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_addr_match.sv
// Combinational region match; lowest matching index wins on overlap.
module apb_addr_match
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] hit_oh_o,
  output logic                  hit_any_o
);

  // Priority encode the region hits into a one-hot select.
  always_comb begin
    hit_oh_o  = '0;
    hit_any_o = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_any_o && ((addr_i & SLV_MASK[i]) == SLV_BASE[i])) begin
        hit_oh_o[i] = 1'b1;
        hit_any_o   = 1'b1;
      end else begin
        hit_oh_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_decoder.sv
// APB 1-to-N address decoder with decode-error responder.
// Optional access timeout enabled by defining APB_DECODER_TIMEOUT_EN.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  APB.Slave                                s_apb,
  output logic [NUM_SLAVES-1:0]            m_psel,
  output logic [ADDR_WIDTH-1:0]            m_paddr,
  output logic [2:0]                       m_pprot,
  output logic                             m_penable,
  output logic                             m_pwrite,
  output logic [DATA_WIDTH-1:0]            m_pwdata,
  output logic [DATA_WIDTH/8-1:0]          m_pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
  input  logic [NUM_SLAVES-1:0]            m_pready,
  input  logic [NUM_SLAVES-1:0]            m_pslverr,
  output logic                             decode_err_o,
  output logic                             timeout_o
);

  apb_dec_state_t          state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   hit_oh_s;
  logic                    hit_any_s;
  logic                    setup_s;
  logic [DATA_WIDTH-1:0]   sel_prdata_s;
  logic                    sel_pready_s;
  logic                    sel_pslverr_s;
  logic [NUM_SLAVES-1:0]   msel_s;
  logic                    menable_s;
  logic                    resp_rdy_s;
  logic                    resp_err_s;
  logic [DATA_WIDTH-1:0]   resp_data_s;
  logic                    derr_s;

`ifdef APB_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_s;
`endif

  apb_addr_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_match (
    .addr_i    (s_apb.paddr),
    .hit_oh_o  (hit_oh_s),
    .hit_any_o (hit_any_s)
  );

  assign setup_s = s_apb.psel & ~s_apb.penable;

  // One-hot mux of the registered slave's response.
  always_comb begin
    sel_prdata_s  = '0;
    sel_pready_s  = 1'b0;
    sel_pslverr_s = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_prdata_s  = sel_prdata_s | m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_pready_s  = sel_pready_s | m_pready[i];
        sel_pslverr_s = sel_pslverr_s | m_pslverr[i];
      end else begin
        sel_prdata_s  = sel_prdata_s;
      end
    end
  end

  // Next state, downstream select and upstream response.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    msel_s      = '0;
    menable_s   = 1'b0;
    resp_rdy_s  = 1'b0;
    resp_err_s  = 1'b0;
    resp_data_s = '0;
    derr_s      = 1'b0;
`ifdef APB_DECODER_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_s       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (setup_s) begin
          msel_s  = hit_oh_s;
          sel_d   = hit_oh_s;
          state_d = hit_any_s ? ACCESS : DERR;
`ifdef APB_DECODER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          sel_d   = '0;
        end
      end
      ACCESS: begin
        if (!s_apb.psel) begin
          state_d = IDLE;
          sel_d   = '0;
        end
`ifdef APB_DECODER_TIMEOUT_EN
        else if (s_apb.penable && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
          resp_rdy_s = 1'b1;
          resp_err_s = 1'b1;
          tmo_s      = 1'b1;
          state_d    = IDLE;
          sel_d      = '0;
        end
`endif
        else begin
          msel_s      = sel_q;
          menable_s   = s_apb.penable;
          resp_rdy_s  = sel_pready_s;
          resp_err_s  = sel_pslverr_s;
          resp_data_s = sel_prdata_s;
          if (s_apb.penable && sel_pready_s) begin
            state_d = IDLE;
            sel_d   = '0;
          end else begin
`ifdef APB_DECODER_TIMEOUT_EN
            if (s_apb.penable) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = cnt_q;
            end
`endif
            state_d = ACCESS;
          end
        end
      end
      DERR: begin
        if (!s_apb.psel) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (s_apb.penable) begin
          resp_rdy_s = 1'b1;
          resp_err_s = 1'b1;
          derr_s     = 1'b1;
          state_d    = IDLE;
          sel_d      = '0;
        end else begin
          state_d    = DERR;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State, captured select and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
`ifdef APB_DECODER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef APB_DECODER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Everything is held at zero while reset is asserted, even the broadcast path.
  assign m_psel        = rst_n ? msel_s       : '0;
  assign m_penable     = rst_n & menable_s;
  assign m_paddr       = rst_n ? s_apb.paddr  : '0;
  assign m_pprot       = rst_n ? s_apb.pprot  : 3'b000;
  assign m_pwrite      = rst_n & s_apb.pwrite;
  assign m_pwdata      = rst_n ? s_apb.pwdata : '0;
  assign m_pstrb       = rst_n ? s_apb.pstrb  : '0;
  assign s_apb.pready  = rst_n & resp_rdy_s;
  assign s_apb.pslverr = rst_n & resp_err_s;
  assign s_apb.prdata  = rst_n ? resp_data_s  : '0;
  assign decode_err_o  = rst_n & derr_s;
`ifdef APB_DECODER_TIMEOUT_EN
  assign timeout_o     = rst_n & tmo_s;
`else
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: doc/apb_decoder.md
APB_DECODER -- requirements
Module: apb_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of downstream APB ports.
REQ-004 SHALL have parameter SLV_BASE, default {0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, packed array of region base addresses.
REQ-005 SHALL have parameter SLV_MASK, default {0xFFFF_0000,0xFFFF_0000,0xFFFF_0000,0xFFFF_F000}, packed array of region match masks.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS wait cycles.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port s_apb, APB.Slave modport, upstream bus (fed by the arbiter's slave_if).
REQ-010 SHALL have port m_psel, output, NUM_SLAVES, per-slave select.
REQ-011 SHALL have ports m_paddr/m_pprot/m_penable/m_pwrite/m_pwdata/m_pstrb, output, ADDR_WIDTH/3/1/1/DATA_WIDTH/DATA_WIDTH/8, shared request broadcast.
REQ-012 SHALL have port m_prdata, input, NUM_SLAVES*DATA_WIDTH, per-slave read data.
REQ-013 SHALL have ports m_pready/m_pslverr, input, NUM_SLAVES each, per-slave handshake.
REQ-014 SHALL have ports decode_err_o/timeout_o, output, 1 each, single-cycle status pulses.

Function
REQ-015 SHALL compute hit[i] = ((s_apb.paddr & SLV_MASK[i]) == SLV_BASE[i]); on overlap lowest index wins.
REQ-016 SHALL implement states IDLE, ACCESS, DERR.
REQ-017 SHALL, in IDLE with s_apb.psel=1 and penable=0, drive m_psel[i]=hit[i] combinationally (zero added latency) and register one-hot sel_q.
REQ-018 SHALL transition IDLE->ACCESS on setup with any hit, IDLE->DERR on setup with no hit.
REQ-019 SHALL, in ACCESS, drive m_psel=sel_q, m_penable=s_apb.penable, and route prdata/pready/pslverr of the selected slave to s_apb.
REQ-020 SHALL leave ACCESS to IDLE when s_apb.penable=1 and selected m_pready=1.
REQ-021 SHALL, in DERR, drive m_psel=0, answer s_apb.penable=1 with pready=1, pslverr=1, prdata=0, pulse decode_err_o, then return to IDLE.
REQ-022 SHALL drive s_apb.pready=0, pslverr=0, prdata=0 whenever no response is routed (IDLE, setup cycle).
REQ-023 SHALL pass m_paddr/m_pprot/m_pwrite/m_pwdata/m_pstrb straight from s_apb in all states.
REQ-024 SHALL return to IDLE without response if s_apb.psel drops in ACCESS or DERR.
REQ-025 SHALL accept back-to-back transfers: setup in the cycle after completion is decoded normally.

Reset
REQ-026 SHALL, on rst_n low, force state IDLE, sel_q=0, wait counter=0, all m_* outputs 0, s_apb responses 0, status pulses 0, including mid-transfer.

Configuration
REQ-027 SHALL, with APB_DECODER_TIMEOUT_EN defined, count ACCESS cycles with selected pready=0 in a $clog2(TIMEOUT_CYCLES+1)-bit counter cleared on entry to ACCESS; on reaching TIMEOUT_CYCLES it SHALL answer pready=1, pslverr=1, prdata=0, deassert m_psel, pulse timeout_o and go IDLE.
REQ-028 SHALL, without APB_DECODER_TIMEOUT_EN, omit the counter, wait indefinitely, and tie timeout_o to 0.

Structure
REQ-029 SHALL place the state enum apb_dec_state_t and default base/mask constants in shared package apb_pkg.
REQ-030 SHALL factor the address match/priority encode into sub-module apb_addr_match (combinational, outputs one-hot and hit-any).

Verification
REQ-031 SHALL cover: write 0x1000_0040 data 0xDEAD_BEEF, slave1 pready after 2 waits -> m_psel=0b0010, s_apb.pready only in 3rd ACCESS cycle, pslverr=0.
REQ-032 SHALL cover: read 0x0000_0FFC, slave0 prdata=0x1234_5678 -> s_apb.prdata=0x1234_5678; 0x0000_1000 misses region 0.
REQ-033 SHALL cover: read 0x4000_0000 -> no m_psel, pready=1, pslverr=1, prdata=0 in first access cycle, decode_err_o one pulse.
REQ-034 SHALL cover (TIMEOUT_EN, TIMEOUT_CYCLES=8): slave2 never ready at 0x2000_0000 -> error response after 8 wait cycles, timeout_o pulse, next transfer to slave3 completes.
REQ-035 SHALL cover: rst_n low during ACCESS to slave1 -> all outputs 0 next edge, state IDLE, following transfer correct.
REQ-036 SHALL cover: back-to-back slave0 then slave3 with pready=1 -> each completes in 2 cycles, no m_psel overlap.
